// File: rtl/sprite_pixel_compositor.sv
// Three-stage sprite compositor: window test, synchronous sprite ROM fetch, and
// transparent-index composite over the background index for the palette lookup.
module sprite_pixel_compositor #(
    parameter  int SPR_W  = 32,
    parameter  int SPR_H  = 32,
    localparam int LW     = $clog2(SPR_W),
    localparam int LH     = $clog2(SPR_H),
    localparam int ROM_AW = LW + LH
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              pix_valid,
    input  logic [3:0]        bg_idx,
    input  logic              frame_start,
    input  logic              pos_load,
    input  logic [9:0]        spr_x_in,
    input  logic [9:0]        spr_y_in,
    input  logic              spr_en_in,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [3:0]        colorIdx,
    output logic              idx_valid,
    output logic              hit,
    output logic              frame_hit
);

    logic [9:0]  r_act_x, r_act_y, r_pend_x, r_pend_y;
    logic        r_act_en, r_pend_en, r_dirty;
    logic        r_inside1, r_valid1, r_inside2, r_valid2;
    logic [3:0]  r_bg1, r_bg2;
    logic        r_acc;

    logic [10:0] w_dx, w_dy;
    logic        w_inside, w_opaque;

    assign w_dx = {1'b0, DrawX} - {1'b0, r_act_x};
    assign w_dy = {1'b0, DrawY} - {1'b0, r_act_y};
    // A borrow in bit 10 means the pixel is left of / above the sprite; no wrap.
    assign w_inside = r_act_en & pix_valid & ~w_dx[10] & ~w_dy[10]
                    & (w_dx < 11'(SPR_W)) & (w_dy < 11'(SPR_H));
    assign w_opaque = r_inside2 & (rom_data != 4'd0);

    // Active copy only changes at frame start; a same-edge load stays pending.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_act_x   <= '0;
            r_act_y   <= '0;
            r_act_en  <= 1'b0;
            r_pend_x  <= '0;
            r_pend_y  <= '0;
            r_pend_en <= 1'b0;
            r_dirty   <= 1'b0;
        end else begin
            if (frame_start && r_dirty) begin
                r_act_x  <= r_pend_x;
                r_act_y  <= r_pend_y;
                r_act_en <= r_pend_en;
            end
            if (pos_load) begin
                r_pend_x  <= spr_x_in;
                r_pend_y  <= spr_y_in;
                r_pend_en <= spr_en_in;
                r_dirty   <= 1'b1;
            end else if (frame_start) begin
                r_dirty <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr  <= '0;
            r_inside1 <= 1'b0;
            r_valid1  <= 1'b0;
            r_bg1     <= '0;
            r_inside2 <= 1'b0;
            r_valid2  <= 1'b0;
            r_bg2     <= '0;
            colorIdx  <= '0;
            idx_valid <= 1'b0;
            hit       <= 1'b0;
        end else begin
            rom_addr  <= w_inside ? {w_dy[LH-1:0], w_dx[LW-1:0]} : '0;
            r_inside1 <= w_inside;
            r_valid1  <= pix_valid;
            r_bg1     <= bg_idx;
            r_inside2 <= r_inside1;
            r_valid2  <= r_valid1;
            r_bg2     <= r_bg1;
            colorIdx  <= r_valid2 ? (w_opaque ? rom_data : r_bg2) : 4'd0;
            hit       <= r_valid2 & w_opaque;
            idx_valid <= r_valid2;
        end
    end

    // A hit coinciding with frame_start belongs to the frame being closed.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_acc     <= 1'b0;
            frame_hit <= 1'b0;
        end else if (frame_start) begin
            frame_hit <= r_acc | hit;
            r_acc     <= 1'b0;
        end else if (hit) begin
            r_acc <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sprite_pixel_compositor.sv
// Directed bench for sprite_pixel_compositor with a constant-fill synchronous ROM model.
module tb_sprite_pixel_compositor;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [9:0]  DrawX, DrawY;
    logic        pix_valid;
    logic [3:0]  bg_idx;
    logic        frame_start, pos_load;
    logic [9:0]  spr_x_in, spr_y_in;
    logic        spr_en_in;
    logic [9:0]  rom_addr;
    logic [3:0]  rom_data;
    logic [3:0]  colorIdx;
    logic        idx_valid, hit, frame_hit;
    logic [3:0]  rom_fill;

    int total = 0;
    int bad   = 0;

    sprite_pixel_compositor #(.SPR_W(32), .SPR_H(32)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .pix_valid(pix_valid), .bg_idx(bg_idx), .frame_start(frame_start),
        .pos_load(pos_load), .spr_x_in(spr_x_in), .spr_y_in(spr_y_in),
        .spr_en_in(spr_en_in), .rom_addr(rom_addr), .rom_data(rom_data),
        .colorIdx(colorIdx), .idx_valid(idx_valid), .hit(hit), .frame_hit(frame_hit)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) rom_data <= rom_fill;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_pos(input logic [9:0] x, input logic [9:0] y, input logic en, input logic with_fs);
        spr_x_in = x; spr_y_in = y; spr_en_in = en;
        pos_load = 1'b1; frame_start = with_fs;
        tick();
        pos_load = 1'b0; frame_start = 1'b0;
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic run_pixel(input string tag, input logic [9:0] x, input logic [9:0] y,
                             input logic [3:0] bg, input logic pv, input logic [31:0] exp_addr,
                             input logic [3:0] exp_col, input logic exp_hit);
        DrawX = x; DrawY = y; bg_idx = bg; pix_valid = pv;
        tick();
        chk({tag, ".addr"}, rom_addr, exp_addr);
        pix_valid = 1'b0;
        tick();
        tick();
        chk({tag, ".col"}, colorIdx, exp_col);
        chk({tag, ".hit"}, hit, exp_hit);
        chk({tag, ".vld"}, idx_valid, pv);
    endtask

    initial begin
        Reset_n = 1'b0; DrawX = '0; DrawY = '0; pix_valid = 1'b0; bg_idx = '0;
        frame_start = 1'b0; pos_load = 1'b0; spr_x_in = '0; spr_y_in = '0;
        spr_en_in = 1'b0; rom_fill = 4'h5;
        #12;
        chk("rst.col", colorIdx, 0);
        chk("rst.vld", idx_valid, 0);
        chk("rst.hit", hit, 0);
        chk("rst.addr", rom_addr, 0);
        chk("rst.fhit", frame_hit, 0);
        Reset_n = 1'b1;
        tick();

        load_pos(10'd100, 10'd50, 1'b1, 1'b0);
        frame_pulse();
        run_pixel("tl",     10'd100, 10'd50, 4'h3, 1'b1, 0,    4'h5, 1'b1);
        run_pixel("br",     10'd131, 10'd81, 4'h3, 1'b1, 1023, 4'h5, 1'b1);
        run_pixel("right",  10'd132, 10'd81, 4'h7, 1'b1, 0,    4'h7, 1'b0);
        run_pixel("left",   10'd99,  10'd50, 4'h2, 1'b1, 0,    4'h2, 1'b0);
        run_pixel("below",  10'd100, 10'd82, 4'h1, 1'b1, 0,    4'h1, 1'b0);
        rom_fill = 4'h0;
        run_pixel("transp", 10'd110, 10'd60, 4'hA, 1'b1, 330,  4'hA, 1'b0);
        rom_fill = 4'h5;
        run_pixel("novld",  10'd110, 10'd60, 4'hA, 1'b0, 0,    4'h0, 1'b0);

        // back-to-back pixels, one per clock
        DrawX = 10'd130; DrawY = 10'd50; bg_idx = 4'h1; pix_valid = 1'b1;
        tick(); chk("strm.addr0", rom_addr, 30);
        DrawX = 10'd131; bg_idx = 4'h2;
        tick(); chk("strm.addr1", rom_addr, 31);
        DrawX = 10'd132; bg_idx = 4'h6;
        tick(); chk("strm.addr2", rom_addr, 0);
        chk("strm.col0", colorIdx, 4'h5);
        pix_valid = 1'b0;
        tick(); chk("strm.col1", colorIdx, 4'h5); chk("strm.hit1", hit, 1);
        tick(); chk("strm.col2", colorIdx, 4'h6); chk("strm.hit2", hit, 0);

        load_pos(10'd630, 10'd470, 1'b1, 1'b0);
        frame_pulse();
        run_pixel("clip",   10'd639, 10'd479, 4'h1, 1'b1, 297, 4'h5, 1'b1);
        run_pixel("nowrap", 10'd5,   10'd479, 4'h4, 1'b1, 0,   4'h4, 1'b0);
        run_pixel("nowrp2", 10'd5,   10'd5,   4'h4, 1'b1, 0,   4'h4, 1'b0);

        load_pos(10'd100, 10'd50, 1'b1, 1'b0);
        frame_pulse();
        load_pos(10'd200, 10'd50, 1'b1, 1'b0);
        run_pixel("buf.old",  10'd100, 10'd50, 4'h3, 1'b1, 0, 4'h5, 1'b1);
        run_pixel("buf.new0", 10'd200, 10'd50, 4'h3, 1'b1, 0, 4'h3, 1'b0);
        frame_pulse();
        run_pixel("buf.new1", 10'd200, 10'd50, 4'h3, 1'b1, 0, 4'h5, 1'b1);
        run_pixel("buf.old1", 10'd100, 10'd50, 4'h3, 1'b1, 0, 4'h3, 1'b0);
        load_pos(10'd300, 10'd50, 1'b1, 1'b1);
        run_pixel("sim0.keep", 10'd200, 10'd50, 4'h3, 1'b1, 0, 4'h5, 1'b1);
        run_pixel("sim0.pend", 10'd300, 10'd50, 4'h3, 1'b1, 0, 4'h3, 1'b0);
        frame_pulse();
        run_pixel("sim0.next", 10'd300, 10'd50, 4'h3, 1'b1, 0, 4'h5, 1'b1);
        load_pos(10'd400, 10'd50, 1'b1, 1'b0);
        load_pos(10'd500, 10'd50, 1'b1, 1'b1);
        run_pixel("sim1.old",  10'd400, 10'd50, 4'h3, 1'b1, 0, 4'h5, 1'b1);
        run_pixel("sim1.pend", 10'd500, 10'd50, 4'h3, 1'b1, 0, 4'h3, 1'b0);
        frame_pulse();
        run_pixel("sim1.next", 10'd500, 10'd60, 4'h3, 1'b1, 320, 4'h5, 1'b1);

        tick(); tick();
        frame_pulse();
        run_pixel("fh.px", 10'd500, 10'd50, 4'h3, 1'b1, 0, 4'h5, 1'b1);
        tick(); tick();
        frame_pulse();
        chk("fh.one", frame_hit, 1);
        tick(); tick();
        frame_pulse();
        chk("fh.none", frame_hit, 0);
        run_pixel("fh.co", 10'd500, 10'd50, 4'h3, 1'b1, 0, 4'h5, 1'b1);
        frame_pulse();
        chk("fh.coinc", frame_hit, 1);
        tick(); tick();
        frame_pulse();
        chk("fh.cleared", frame_hit, 0);

        DrawX = 10'd500; DrawY = 10'd50; bg_idx = 4'h9; pix_valid = 1'b1;
        tick(); tick(); tick();
        chk("mid.col", colorIdx, 4'h5);
        #2 Reset_n = 1'b0;
        #1;
        chk("mrst.col", colorIdx, 0);
        chk("mrst.vld", idx_valid, 0);
        chk("mrst.hit", hit, 0);
        chk("mrst.addr", rom_addr, 0);
        #2 Reset_n = 1'b1;
        tick(); chk("rel.e1", idx_valid, 0);
        tick(); chk("rel.e2", idx_valid, 0);
        tick(); chk("rel.e3", idx_valid, 1);
        chk("rel.col", colorIdx, 4'h9);
        chk("rel.hit", hit, 0);
        pix_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_pixel_compositor.md
Name: sprite_pixel_compositor

Overview:
Pipelined pixel-index source that sits directly upstream of the 16-entry palette lookup. For each scan coordinate from the VGA controller it tests one sprite window, fetches the sprite's 4-bit colour index from an external synchronous sprite ROM, and composites it over a background index. Index 0 is transparent. Output is a registered 4-bit colorIdx plus a valid flag, ready to drive the palette lookup. Sprite position is double-buffered so updates only take effect at frame start.

Parameters:
SPR_W, 32, sprite width in pixels; power of two, 2..256
SPR_H, 32, sprite height in pixels; power of two, 2..256
(derived, not overridable) ROM_AW = log2(SPR_W) + log2(SPR_H)

Ports:
Clk  in  1  system clock, all state on rising edge
Reset_n  in  1  asynchronous active-low reset
DrawX  in  10  current pixel X, sampled in stage 0
DrawY  in  10  current pixel Y, sampled in stage 0
pix_valid  in  1  active-video qualifier for DrawX/DrawY
bg_idx  in  4  background colour index, aligned with DrawX/DrawY
frame_start  in  1  one-cycle pulse at vertical sync start
pos_load  in  1  one-cycle strobe: capture spr_x_in/spr_y_in/spr_en_in into pending
spr_x_in  in  10  sprite top-left X
spr_y_in  in  10  sprite top-left Y
spr_en_in  in  1  sprite enable
rom_addr  out  ROM_AW  registered sprite ROM address
rom_data  in  4  sprite ROM data; one-cycle read latency after rom_addr
colorIdx  out  4  composited colour index to the palette lookup
idx_valid  out  1  colorIdx corresponds to an active-video pixel
hit  out  1  current colorIdx came from an opaque sprite pixel
frame_hit  out  1  previous frame contained at least one hit

Behaviour:
- Reset (async, Reset_n=0): all outputs 0; active and pending position/enable 0; dirty 0; pipeline valid/inside bits 0; hit accumulator 0.
- Position buffering:
  - pos_load=1 writes pending regs and sets dirty=1.
  - On frame_start with dirty=1, pending is copied to active and dirty clears.
  - If pos_load and frame_start occur together, active receives the pending contents from before the edge (only if dirty was 1). The new load is stored in pending with dirty=1 and takes effect at the next frame_start.
- Stage 0 (combinational, cycle t):
  - dx = {1'b0,DrawX} - {1'b0,act_x} and dy likewise, both 11 bits.
  - inside = act_en & pix_valid & ~dx[10] & ~dy[10] & (dx < SPR_W) & (dy < SPR_H).
  - Sprites partly off the right or bottom edge simply clip; there is no wrap-around.
- Stage 1 (edge ending t):
  - rom_addr <= inside ? {dy[log2H-1:0], dx[log2W-1:0]} : 0.
  - Register inside1, bg1, valid1 = pix_valid.
- Stage 2 (edge ending t+1): rom_data now valid; register inside2, bg2, valid2.
- Stage 3 (edge ending t+2):
  - opaque = inside2 & (rom_data != 0).
  - colorIdx <= valid2 ? (opaque ? rom_data : bg2) : 0.
  - hit <= valid2 & opaque; idx_valid <= valid2.
- Latency: exactly 3 clock edges from DrawX/DrawY sampling to colorIdx. Fully pipelined, one pixel per clock, no stalls.
- Frame hit flag:
  - acc sets when hit=1.
  - On frame_start: frame_hit <= acc | hit, and acc <= 0.
  - A hit in the same cycle as frame_start counts toward the closing frame.
- Position change at frame_start affects only pixels sampled after that edge; pixels already in flight keep their old window.

Test Plan:
- Reset mid-stream: assert Reset_n=0 while pix_valid=1 -> colorIdx=0, idx_valid=0, hit=0, rom_addr=0 immediately (async). After release, first valid output appears 3 edges after the first pix_valid.
- Sprite at (100,50), enabled, ROM returns 4'h5: DrawX=100,DrawY=50 -> rom_addr=0 after 1 edge, colorIdx=5 and hit=1 after 3 edges. DrawX=131,DrawY=81 -> rom_addr=1023. DrawX=132 -> colorIdx=bg_idx, hit=0.
- Transparency: inside window with rom_data=0 and bg_idx=4'hA -> colorIdx=A, hit=0. pix_valid=0 anywhere -> colorIdx=0, idx_valid=0.
- Clipping: sprite at (630,470), DrawX=639,DrawY=479 -> rom_addr={5'd9,5'd9}=297. DrawX=5 -> not inside, no wrap-around.
- Buffering: pos_load with x=200 mid-frame -> rendering stays at old x until frame_start. pos_load and frame_start together with dirty=0 -> active unchanged, new position applied at the following frame_start.
- frame_hit: a frame with one opaque pixel -> frame_hit=1 after the next frame_start. A frame with none -> frame_hit=0. A hit coinciding with frame_start -> frame_hit=1.
